// File: rtl/alu_op_decoder_pkg.sv
// ---------------------------------------------------------------------------
// alu_op_decoder_pkg
//   Shared types for the ALU control interface: the ALU function encoding,
//   the RV32I opcodes and funct7 values this decoder understands, and the
//   packed control bundle that travels from decode to execute.
//   No ports; imported by alu_ctrl_decode and alu_op_decoder.
// ---------------------------------------------------------------------------
package alu_op_decoder_pkg;

  // ALU function codes deliberately share the funct3 encoding so decode is
  // a straight copy of instr[14:12].
  typedef enum logic [2:0] {
    FN_ADD_SUB = 3'b000,
    FN_SLL     = 3'b001,
    FN_SLT     = 3'b010,
    FN_SLTU    = 3'b011,
    FN_XOR     = 3'b100,
    FN_SRL_SRA = 3'b101,
    FN_OR      = 3'b110,
    FN_AND     = 3'b111
  } ALU_FN_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // The immediate is carried at 32 bits (already sign- or zero-extended);
  // the top-level widens it to the configured datapath width.
  typedef struct packed {
    ALU_FN_t     fn;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_op_decoder_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
//   Purely combinational decode of one RV32I OP / OP-IMM instruction word
//   into the ALU control bundle.
//   Ports:
//     instr  in   32-bit instruction word
//     ctrl   out  decoded alu_ctrl_t bundle
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_op_decoder_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices always follow the instruction bits, even for illegal
  // words, so downstream trap logic can still report them.
  always_comb begin
    ctrl         = '0;
    ctrl.rd      = instr[11:7];
    ctrl.rs1     = instr[19:15];
    ctrl.rs2     = instr[24:20];
    ctrl.fn      = ALU_FN_t'(funct3);
    legal        = 1'b0;

    case (opcode)
      OPC_OP: begin
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
        ctrl.funct7 = funct7;
      end

      OPC_OP_IMM: begin
        ctrl.use_imm = 1'b1;
        case (funct3)
          3'b001: begin
            legal       = (funct7 == F7_BASE);
            ctrl.funct7 = funct7;
            ctrl.imm    = {27'd0, instr[24:20]};
          end
          3'b101: begin
            legal       = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            ctrl.funct7 = funct7;
            ctrl.imm    = {27'd0, instr[24:20]};
          end
          default: begin
            // Upper imm bits must not leak into funct7, otherwise a negative
            // ADDI would look like a subtract to the ALU.
            legal       = 1'b1;
            ctrl.funct7 = F7_BASE;
            ctrl.imm    = {{20{instr[31]}}, instr[31:20]};
          end
        endcase
      end

      default: legal = 1'b0;
    endcase

    // Illegal words are still passed along but neutralised to a plain ADD
    // on registers so the ALU never sees a half-valid encoding.
    if (!legal) begin
      ctrl.fn      = FN_ADD_SUB;
      ctrl.funct7  = F7_BASE;
      ctrl.imm     = '0;
      ctrl.use_imm = 1'b0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
//   Pipelined decode stage for RV32I OP / OP-IMM words. One output register
//   plus a one-entry skid buffer keeps full throughput under backpressure
//   while in_ready stays a pure register output.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     instruction-side handshake
//     in_instr              instruction word
//     out_valid/out_ready   ALU-side handshake
//     out_fn .. out_illegal decoded control bundle (held while stalled)
// ---------------------------------------------------------------------------
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output ALU_FN_t          out_fn,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [WIDTH-1:0] out_imm,
  output logic             out_use_imm,
  output logic             out_illegal
);

  alu_ctrl_t dec;
  alu_ctrl_t out_q;
  alu_ctrl_t skid_q;
  logic      out_valid_q;
  logic      skid_full_q;
  logic      accept;
  logic      load_out;

  alu_ctrl_decode u_decode (
    .instr (in_instr),
    .ctrl  (dec)
  );

  // Accepting only depends on the skid being free, never on in_valid.
  assign in_ready = !skid_full_q;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid_q || out_ready;

  // The output slot refills whenever it is empty or draining; the skid
  // entry is older than any new input so it always wins, which keeps order.
  // A word accepted while the output is stalled parks in the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      if (load_out) begin
        out_valid_q <= skid_full_q || accept;
        skid_full_q <= 1'b0;
        if (skid_full_q) begin
          out_q <= skid_q;
        end else if (accept) begin
          out_q <= dec;
        end
      end else if (accept) begin
        skid_q      <= dec;
        skid_full_q <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_fn      = out_q.fn;
  assign out_funct7  = out_q.funct7;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = WIDTH'($signed(out_q.imm));
  assign out_use_imm = out_q.use_imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_op_decoder
//   Self-checking bench for alu_op_decoder. Accepted words push their
//   reference decode into a queue; every output transfer pops and compares.
// ---------------------------------------------------------------------------
module tb_alu_op_decoder;
  import alu_op_decoder_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  ALU_FN_t          out_fn;
  logic [6:0]       out_funct7;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [WIDTH-1:0] out_imm;
  logic             out_use_imm;
  logic             out_illegal;

  int checks = 0;
  int failures = 0;

  logic [58:0] sb[$];
  logic        hold_pending = 1'b0;
  logic [58:0] held = '0;

  alu_op_decoder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fn      (out_fn),
    .out_funct7  (out_funct7),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_use_imm (out_use_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Hard stop in case a wait loop is broken.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [58:0] dutBundle();
    return {out_fn, out_funct7, out_rs1, out_rs2, out_rd, out_imm[31:0], out_use_imm, out_illegal};
  endfunction

  // Reference decode: decide legality first, then fill in the fields.
  function automatic logic [58:0] model(input logic [31:0] w);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_op, is_imm, bad, shift;
    logic [2:0]  e_fn;
    logic [6:0]  e_f7;
    logic [31:0] e_imm;
    op     = w[6:0];
    f3     = w[14:12];
    f7     = w[31:25];
    is_op  = (op == 7'h33);
    is_imm = (op == 7'h13);
    shift  = is_imm && (f3 == 3'd1 || f3 == 3'd5);
    bad = !(is_op || is_imm)
       || (is_op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
       || (is_imm && f3 == 3'd1 && f7 != 7'h00)
       || (is_imm && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    if (bad) begin
      return {3'd0, 7'd0, w[19:15], w[24:20], w[11:7], 32'd0, 1'b0, 1'b1};
    end
    e_fn  = f3;
    e_f7  = (is_op || shift) ? f7 : 7'd0;
    if (is_op)      e_imm = 32'd0;
    else if (shift) e_imm = {27'd0, w[24:20]};
    else            e_imm = {{20{w[31]}}, w[31:20]};
    return {e_fn, e_f7, w[19:15], w[24:20], w[11:7], e_imm, is_imm, 1'b0};
  endfunction

  // One clock cycle, entered and left at a falling edge. Inputs are driven
  // here and both handshakes are judged from the values the coming rising
  // edge will see.
  task automatic doCycle(input logic v, input logic [31:0] w, input logic r, output logic accepted);
    if (hold_pending) begin
      checkOutput("stable", {4'd0, out_valid, dutBundle()}, {4'd0, 1'b1, held});
    end
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    accepted  = v && in_ready;
    if (accepted) sb.push_back(model(w));
    if (out_valid && r) begin
      if (sb.size() == 0) checkOutput("unexpected_out", 64'd1, 64'd0);
      else                checkOutput("bundle", {5'd0, dutBundle()}, {5'd0, sb.pop_front()});
    end
    hold_pending = out_valid && !r;
    held         = dutBundle();
    @(negedge clk);
  endtask

  // Offer one word with out_ready high until it is accepted.
  task automatic applyStimulus(input logic [31:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      doCycle(1'b1, w, 1'b1, acc);
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    int          pick;
    int          k;
    w    = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 5)      w[6:0] = 7'h33;
    else if (pick < 9) w[6:0] = 7'h13;
    k = $urandom_range(0, 3);
    if (k < 2)       w[31:25] = 7'h00;
    else if (k == 2) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    logic        acc;
    logic [31:0] cur;
    logic        have;
    int          sent;
    int          cyc;

    // Reset state
    #12;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_payload", {5'd0, dutBundle()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // add x3,x1,x2
    applyStimulus(32'h002081B3);
    checkOutput("add_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("add_fields", {45'd0, out_fn, out_funct7, out_rs1, out_rs2, out_rd},
                {45'd0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3});
    checkOutput("add_flags", {62'd0, out_use_imm, out_illegal}, 64'd0);

    // sub
    applyStimulus(32'h402081B3);
    checkOutput("sub_f7_fn", {54'd0, out_funct7, out_fn}, {54'd0, 7'h20, 3'd0});

    // addi x5,x0,-1
    applyStimulus(32'hFFF00293);
    checkOutput("addi_f7", {57'd0, out_funct7}, 64'd0);
    checkOutput("addi_imm", {32'd0, out_imm}, 64'hFFFFFFFF);
    checkOutput("addi_use_rd", {58'd0, out_use_imm, out_rd}, {58'd0, 1'b1, 5'd5});

    // srai x1,x1,3
    applyStimulus(32'h4030D093);
    checkOutput("srai_fn_f7", {54'd0, out_fn, out_funct7}, {54'd0, 3'd5, 7'h20});
    checkOutput("srai_imm", {32'd0, out_imm}, 64'd3);

    // slli with funct7=0000001 is illegal
    applyStimulus(32'h02009093);
    checkOutput("slli_bad", {53'd0, out_illegal, out_fn, out_funct7}, {53'd0, 1'b1, 3'd0, 7'd0});

    // lui is not an OP/OP-IMM word; rd still passes through
    applyStimulus(32'h123450B7);
    checkOutput("lui_bad", {57'd0, out_illegal, out_use_imm, out_rd}, {57'd0, 1'b1, 1'b0, 5'd1});
    doCycle(1'b0, 32'd0, 1'b1, acc);

    // Backpressure: A, B, C with out_ready low
    doCycle(1'b1, 32'h002081B3, 1'b0, acc);
    checkOutput("bp_acc_a", {63'd0, acc}, 64'd1);
    doCycle(1'b1, 32'h402081B3, 1'b0, acc);
    checkOutput("bp_acc_b", {63'd0, acc}, 64'd1);
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_hold_a", {59'd0, out_rd}, 64'd3);
    doCycle(1'b1, 32'hFFF00293, 1'b0, acc);
    checkOutput("bp_block_c", {63'd0, acc}, 64'd0);
    doCycle(1'b1, 32'hFFF00293, 1'b1, acc);
    checkOutput("bp_block_c2", {63'd0, acc}, 64'd0);
    doCycle(1'b1, 32'hFFF00293, 1'b1, acc);
    checkOutput("bp_acc_c", {63'd0, acc}, 64'd1);
    doCycle(1'b0, 32'd0, 1'b1, acc);
    checkOutput("bp_empty", 64'(sb.size()), 64'd0);

    // Random traffic
    sent = 0;
    cyc  = 0;
    have = 1'b0;
    cur  = '0;
    while (sent < 1000 && cyc < 20000) begin
      if (!have) begin
        cur  = randWord();
        have = ($urandom_range(0, 3) != 0);
      end
      doCycle(have, cur, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    checkOutput("rand_sent", 64'(sent), 64'd1000);
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      doCycle(1'b0, 32'd0, 1'b1, acc);
      cyc++;
    end
    checkOutput("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with both entries occupied
    doCycle(1'b1, 32'h002081B3, 1'b0, acc);
    doCycle(1'b1, 32'h402081B3, 1'b0, acc);
    checkOutput("mid_full", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    doCycle(1'b1, 32'hFFF00293, 1'b1, acc);
    checkOutput("post_rst_acc", {63'd0, acc}, 64'd1);
    checkOutput("post_rst_out", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'd5});
    doCycle(1'b0, 32'd0, 1'b1, acc);
    checkOutput("post_rst_empty", {63'd0, out_valid}, 64'd0);
    checkOutput("final_sb", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
